// File: rtl/turf_udp_pkg.sv
// Shared types and field layout for the TURF UDP read/write initiator.
// Optional timeout support is enabled by defining TURF_UDP_INIT_TIMEOUT_EN.
package turf_udp_pkg;

    localparam int unsigned TDATA_W = 64;
    localparam int unsigned KEEP_W  = 8;
    localparam int unsigned ADR_W   = 28;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned TMO_W   = 16;

    // Header word layout: {ip, port, length}
    localparam int unsigned HDR_IP_LSB   = 32;
    localparam int unsigned HDR_PORT_LSB = 16;
    localparam logic [HDR_PORT_LSB-1:0] HDR_LEN = 16'd8;

    // Payload word layout: {dat, wr, rsvd, adr}
    localparam int unsigned ADR_MSB = 27;
    localparam int unsigned WR_BIT  = 31;
    localparam int unsigned DAT_LSB = 32;

    localparam logic [DAT_W-1:0] TMO_DAT = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_HDR = 3'd1,
        S_SEND_PAY = 3'd2,
        S_WAIT_HDR = 3'd3,
        S_WAIT_PAY = 3'd4,
        S_DRAIN    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    typedef struct packed {
        logic [TDATA_W-HDR_IP_LSB-1:0]        ip;
        logic [HDR_IP_LSB-HDR_PORT_LSB-1:0]   port;
        logic [HDR_PORT_LSB-1:0]              len;
    } udp_hdr_t;

    typedef struct packed {
        logic [TDATA_W-DAT_LSB-1:0] dat;
        logic                       wr;
        logic [WR_BIT-ADR_MSB-2:0]  rsvd;
        logic [ADR_MSB:0]           adr;
    } udp_pay_t;

    function automatic udp_hdr_t make_hdr(input logic [31:0] ip, input logic [15:0] port);
        udp_hdr_t h;
        h.ip   = ip;
        h.port = port;
        h.len  = HDR_LEN;
        return h;
    endfunction

    // Read requests carry a zero data field.
    function automatic udp_pay_t make_pay(input logic wr, input logic [ADR_W-1:0] adr,
                                          input logic [DAT_W-1:0] dat);
        udp_pay_t p;
        p.dat  = wr ? dat : '0;
        p.wr   = wr;
        p.rsvd = '0;
        p.adr  = adr;
        return p;
    endfunction

endpackage

// File: rtl/turf_udp_timeout.sv
// Response timeout counter; only built when TURF_UDP_INIT_TIMEOUT_EN is defined.
`ifdef TURF_UDP_INIT_TIMEOUT_EN
module turf_udp_timeout
    import turf_udp_pkg::*;
#(
    parameter logic [TMO_W-1:0] LIMIT = 16'd65535
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired_c
);

    logic [TMO_W-1:0] r_cnt;

    // Saturates at LIMIT so a stuck run flag cannot wrap back to zero.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expired_c = i_run && (r_cnt == LIMIT);

endmodule
`endif

// File: rtl/turf_udp_rdwr_initiator.sv
// Issues one TURF UDP register request frame per command and reports the response.
// Define TURF_UDP_INIT_TIMEOUT_EN to abandon responses after TIMEOUT cycles.
module turf_udp_rdwr_initiator
    import turf_udp_pkg::*;
#(
    parameter logic [31:0] DEST_IP = 32'hC0A8_0180,
    parameter logic [15:0] RD_PORT = 16'd21618,
    parameter logic [15:0] WR_PORT = 16'd21623,
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic               aclk,
    input  logic               aresetn,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,

    output logic               rsp_valid,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,

    output logic [TDATA_W-1:0] m_hdr_tdata,
    output logic               m_hdr_tvalid,
    input  logic               m_hdr_tready,
    output logic               m_hdr_tuser,

    output logic [TDATA_W-1:0] m_payload_tdata,
    output logic               m_payload_tvalid,
    input  logic               m_payload_tready,
    output logic [KEEP_W-1:0]  m_payload_tkeep,
    output logic               m_payload_tlast,

    input  logic [TDATA_W-1:0] s_hdr_tdata,
    input  logic               s_hdr_tvalid,
    output logic               s_hdr_tready,
    input  logic               s_hdr_tuser,

    input  logic [TDATA_W-1:0] s_payload_tdata,
    input  logic               s_payload_tvalid,
    output logic               s_payload_tready,
    input  logic [KEEP_W-1:0]  s_payload_tkeep,
    input  logic               s_payload_tlast
);

    state_t r_state, w_nxt;

    logic               r_cmd_ready;
    logic               r_m_hdr_tvalid;
    logic               r_m_hdr_tuser;
    logic [TDATA_W-1:0] r_m_hdr_tdata;
    logic               r_m_pay_tvalid;
    logic [TDATA_W-1:0] r_m_pay_tdata;
    logic [KEEP_W-1:0]  r_m_pay_tkeep;
    logic               r_m_pay_tlast;
    logic               r_s_hdr_tready;
    logic               r_s_pay_tready;
    logic               r_rsp_valid;
    logic [DAT_W-1:0]   r_rsp_dat;
    logic               r_rsp_err;
    logic               r_tuser_ok;
    logic               r_match;

    logic w_cmd_hs, w_mh_hs, w_mp_hs, w_sh_hs, w_sp_hs;
    logic w_match_c, w_timeout;
    logic w_unused;

    assign w_cmd_hs = cmd_valid & r_cmd_ready;
    assign w_mh_hs  = r_m_hdr_tvalid & m_hdr_tready;
    assign w_mp_hs  = r_m_pay_tvalid & m_payload_tready;
    assign w_sh_hs  = s_hdr_tvalid & r_s_hdr_tready;
    assign w_sp_hs  = s_payload_tvalid & r_s_pay_tready;

    // Response matches when the port flag agrees and the low word echoes the request.
    assign w_match_c = r_tuser_ok
                     & (s_payload_tdata[DAT_LSB-1:0] == r_m_pay_tdata[DAT_LSB-1:0])
                     & (s_payload_tkeep == {KEEP_W{1'b1}});

    // Response header contents carry no information this block checks.
    assign w_unused = ^s_hdr_tdata;

`ifdef TURF_UDP_INIT_TIMEOUT_EN
    logic w_tmo_clr, w_tmo_run, w_tmo_exp_c;

    assign w_tmo_clr = (r_state == S_SEND_PAY) && w_mp_hs;
    assign w_tmo_run = (r_state == S_WAIT_HDR) || (r_state == S_WAIT_PAY);

    turf_udp_timeout #(
        .LIMIT       (TIMEOUT)
    ) u_timeout (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_clear     (w_tmo_clr),
        .i_run       (w_tmo_run),
        .o_expired_c (w_tmo_exp_c)
    );

    assign w_timeout = w_tmo_exp_c;
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_cmd_hs) w_nxt = S_SEND_HDR;
            S_SEND_HDR: if (w_mh_hs)  w_nxt = S_SEND_PAY;
            S_SEND_PAY: if (w_mp_hs)  w_nxt = S_WAIT_HDR;
            S_WAIT_HDR: if (w_sh_hs)  w_nxt = S_WAIT_PAY;
            S_WAIT_PAY: if (w_sp_hs)  w_nxt = s_payload_tlast ? S_DONE : S_DRAIN;
            S_DRAIN:    if (w_sp_hs && s_payload_tlast) w_nxt = S_DONE;
            S_DONE:     w_nxt = S_IDLE;
            default:    w_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_nxt = S_DONE;
        end
    end

    // Stream flags are registered from the next state so they line up with it.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cmd_ready    <= 1'b0;
            r_m_hdr_tvalid <= 1'b0;
            r_m_hdr_tuser  <= 1'b0;
            r_m_hdr_tdata  <= '0;
            r_m_pay_tvalid <= 1'b0;
            r_m_pay_tdata  <= '0;
            r_m_pay_tkeep  <= '0;
            r_m_pay_tlast  <= 1'b0;
            r_s_hdr_tready <= 1'b0;
            r_s_pay_tready <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_dat      <= '0;
            r_rsp_err      <= 1'b0;
            r_tuser_ok     <= 1'b0;
            r_match        <= 1'b0;
        end else begin
            r_cmd_ready    <= (w_nxt == S_IDLE);
            r_m_hdr_tvalid <= (w_nxt == S_SEND_HDR);
            r_m_pay_tvalid <= (w_nxt == S_SEND_PAY);
            r_m_pay_tkeep  <= (w_nxt == S_SEND_PAY) ? {KEEP_W{1'b1}} : '0;
            r_m_pay_tlast  <= (w_nxt == S_SEND_PAY);
            r_s_hdr_tready <= (w_nxt == S_IDLE) || (w_nxt == S_WAIT_HDR);
            r_s_pay_tready <= (w_nxt == S_IDLE) || (w_nxt == S_WAIT_PAY) || (w_nxt == S_DRAIN);
            r_rsp_valid    <= (w_nxt == S_DONE);
            r_rsp_err      <= 1'b0;

            if (w_cmd_hs) begin
                r_m_hdr_tdata <= make_hdr(DEST_IP, cmd_wr ? WR_PORT : RD_PORT);
                r_m_hdr_tuser <= ~cmd_wr;
                r_m_pay_tdata <= make_pay(cmd_wr, cmd_adr, cmd_dat);
            end

            if ((r_state == S_WAIT_HDR) && w_sh_hs) begin
                r_tuser_ok <= (s_hdr_tuser == r_m_hdr_tuser);
            end

            if ((r_state == S_WAIT_PAY) && w_sp_hs) begin
                r_match   <= w_match_c;
                r_rsp_dat <= s_payload_tdata[TDATA_W-1:DAT_LSB];
            end

            if (w_nxt == S_DONE) begin
                if (w_timeout) begin
                    r_rsp_err <= 1'b1;
                    r_rsp_dat <= TMO_DAT;
                end else if (r_state == S_WAIT_PAY) begin
                    r_rsp_err <= ~w_match_c;
                end else begin
                    r_rsp_err <= ~r_match;
                end
            end
        end
    end

    assign cmd_ready        = r_cmd_ready;
    assign m_hdr_tvalid     = r_m_hdr_tvalid;
    assign m_hdr_tuser      = r_m_hdr_tuser;
    assign m_hdr_tdata      = r_m_hdr_tdata;
    assign m_payload_tvalid = r_m_pay_tvalid;
    assign m_payload_tdata  = r_m_pay_tdata;
    assign m_payload_tkeep  = r_m_pay_tkeep;
    assign m_payload_tlast  = r_m_pay_tlast;
    assign s_hdr_tready     = r_s_hdr_tready;
    assign s_payload_tready = r_s_pay_tready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_dat          = r_rsp_dat;
    assign rsp_err          = r_rsp_err;

endmodule

// File: tb/tb_turf_udp_rdwr_initiator.sv
// Directed bench for turf_udp_rdwr_initiator; timeout case runs when TURF_UDP_INIT_TIMEOUT_EN is defined.
module tb_turf_udp_rdwr_initiator;

    localparam logic [31:0] DEST_IP = 32'hC0A8_0180;
    localparam logic [15:0] RD_PORT = 16'd21618;
    localparam logic [15:0] WR_PORT = 16'd21623;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [27:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    logic [63:0] m_hdr_tdata, m_payload_tdata, s_hdr_tdata, s_payload_tdata;
    logic        m_hdr_tvalid, m_hdr_tready, m_hdr_tuser;
    logic        m_payload_tvalid, m_payload_tready, m_payload_tlast;
    logic [7:0]  m_payload_tkeep, s_payload_tkeep;
    logic        s_hdr_tvalid, s_hdr_tready, s_hdr_tuser;
    logic        s_payload_tvalid, s_payload_tready, s_payload_tlast;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rsp    = 0;
    int exp_rsp  = 0;
    int cyc      = 0;
    int t_acc    = 0;

    turf_udp_rdwr_initiator #(
        .DEST_IP (DEST_IP),
        .RD_PORT (RD_PORT),
        .WR_PORT (WR_PORT),
        .TIMEOUT (16'd100)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_wr           (cmd_wr),
        .cmd_adr          (cmd_adr),
        .cmd_dat          (cmd_dat),
        .rsp_valid        (rsp_valid),
        .rsp_dat          (rsp_dat),
        .rsp_err          (rsp_err),
        .m_hdr_tdata      (m_hdr_tdata),
        .m_hdr_tvalid     (m_hdr_tvalid),
        .m_hdr_tready     (m_hdr_tready),
        .m_hdr_tuser      (m_hdr_tuser),
        .m_payload_tdata  (m_payload_tdata),
        .m_payload_tvalid (m_payload_tvalid),
        .m_payload_tready (m_payload_tready),
        .m_payload_tkeep  (m_payload_tkeep),
        .m_payload_tlast  (m_payload_tlast),
        .s_hdr_tdata      (s_hdr_tdata),
        .s_hdr_tvalid     (s_hdr_tvalid),
        .s_hdr_tready     (s_hdr_tready),
        .s_hdr_tuser      (s_hdr_tuser),
        .s_payload_tdata  (s_payload_tdata),
        .s_payload_tvalid (s_payload_tvalid),
        .s_payload_tready (s_payload_tready),
        .s_payload_tkeep  (s_payload_tkeep),
        .s_payload_tlast  (s_payload_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        cyc++;
        if (rsp_valid) n_rsp++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [27:0] adr, input logic [31:0] dat, input bit bp);
        int n;
        if (bp) repeat ($urandom_range(0, 2)) @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_adr   = adr;
        cmd_dat   = dat;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        t_acc = cyc;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_req(input logic [63:0] eh, input logic [63:0] ep, input logic etuser, input bit bp);
        int n;
        bit hs;
        n = 0;
        while (!m_hdr_tvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("hdr_tvalid", m_hdr_tvalid, 1);
        hs = 0;
        n  = 0;
        while (!hs && n < 50) begin
            chk("hdr_tdata", m_hdr_tdata, eh);
            chk("hdr_tuser", m_hdr_tuser, etuser);
            chk("hdr_excl_pay", m_payload_tvalid, 0);
            m_hdr_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = m_hdr_tready && m_hdr_tvalid;
            @(negedge aclk);
            n++;
        end
        chk("pay_tvalid_next", m_payload_tvalid, 1);
        hs = 0;
        n  = 0;
        while (!hs && n < 50) begin
            chk("pay_tdata", m_payload_tdata, ep);
            chk("pay_tkeep", m_payload_tkeep, 8'hFF);
            chk("pay_tlast", m_payload_tlast, 1);
            chk("pay_excl_hdr", m_hdr_tvalid, 0);
            m_payload_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = m_payload_tready && m_payload_tvalid;
            @(negedge aclk);
            n++;
        end
        m_hdr_tready     = 1'b1;
        m_payload_tready = 1'b1;
    endtask

    task automatic send_rsp(input logic tuser, input logic [63:0] b0, input logic [7:0] k0,
                            input int nb, input bit bp);
        int n;
        if (bp) repeat ($urandom_range(0, 3)) @(negedge aclk);
        s_hdr_tvalid = 1'b1;
        s_hdr_tuser  = tuser;
        s_hdr_tdata  = {$urandom, $urandom};
        n = 0;
        while (!s_hdr_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("s_hdr_tready_wait", s_hdr_tready, 1);
        @(negedge aclk);
        s_hdr_tvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (bp) repeat ($urandom_range(0, 2)) @(negedge aclk);
            s_payload_tvalid = 1'b1;
            s_payload_tdata  = (i == 0) ? b0 : {$urandom, $urandom};
            s_payload_tkeep  = (i == 0) ? k0 : 8'hFF;
            s_payload_tlast  = (i == nb - 1);
            n = 0;
            while (!s_payload_tready && n < 50) begin
                @(negedge aclk);
                n++;
            end
            chk("s_pay_tready_wait", s_payload_tready, 1);
            @(negedge aclk);
            s_payload_tvalid = 1'b0;
            s_payload_tlast  = 1'b0;
        end
    endtask

    task automatic expect_rsp(input logic [31:0] edat, input logic eerr);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        exp_rsp++;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_dat", rsp_dat, edat);
        chk("rsp_err", rsp_err, eerr);
        @(negedge aclk);
        chk("rsp_one_cycle", rsp_valid, 0);
    endtask

    initial begin
        int t_prev;
        logic        rw;
        logic [27:0] ra;
        logic [31:0] rd, rr, hi;
        aresetn          = 1'b0;
        cmd_valid        = 1'b0;
        cmd_wr           = 1'b0;
        cmd_adr          = '0;
        cmd_dat          = '0;
        m_hdr_tready     = 1'b1;
        m_payload_tready = 1'b1;
        s_hdr_tvalid     = 1'b0;
        s_hdr_tuser      = 1'b0;
        s_hdr_tdata      = '0;
        s_payload_tvalid = 1'b0;
        s_payload_tdata  = '0;
        s_payload_tkeep  = '0;
        s_payload_tlast  = 1'b0;

        // Reset values
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_hdr_tvalid", m_hdr_tvalid, 0);
        chk("rst_pay_tvalid", m_payload_tvalid, 0);
        chk("rst_s_hdr_tready", s_hdr_tready, 0);
        chk("rst_s_pay_tready", s_payload_tready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("idle_s_hdr_tready", s_hdr_tready, 1);
        chk("idle_s_pay_tready", s_payload_tready, 1);

        // Read 0x10; data field must be zeroed despite cmd_dat
        send_cmd(1'b0, 28'h0000010, 32'hFFFF_FFFF, 1'b0);
        t_prev = t_acc;
        chk("hdr_latency", m_hdr_tvalid, 1);
        expect_req(64'hC0A80180_54720008, 64'h00000000_00000010, 1'b1, 1'b0);
        chk("wait_hdr_s_hdr_tready", s_hdr_tready, 1);
        chk("wait_hdr_s_pay_tready", s_payload_tready, 0);
        send_rsp(1'b1, 64'h12345678_00000010, 8'hFF, 1, 1'b0);
        chk("rsp_latency", rsp_valid, 1);
        expect_rsp(32'h12345678, 1'b0);

        // Write 0x20 back-to-back; 6-cycle command period
        send_cmd(1'b1, 28'h0000020, 32'hCAFEF00D, 1'b0);
        chk("cmd_period", 64'(t_acc - t_prev), 64'd6);
        expect_req(64'hC0A80180_54770008, 64'hCAFEF00D_80000020, 1'b0, 1'b0);
        send_rsp(1'b0, 64'hCAFEF00D_80000020, 8'hFF, 1, 1'b0);
        expect_rsp(32'hCAFEF00D, 1'b0);

        // Low-word mismatch
        send_cmd(1'b0, 28'h0000010, 32'h0, 1'b0);
        expect_req(64'hC0A80180_54720008, 64'h00000000_00000010, 1'b1, 1'b0);
        send_rsp(1'b1, 64'h9ABCDEF0_00000011, 8'hFF, 1, 1'b0);
        expect_rsp(32'h9ABCDEF0, 1'b1);

        // Port flag mismatch
        send_cmd(1'b0, 28'h0000040, 32'h0, 1'b0);
        expect_req(64'hC0A80180_54720008, 64'h00000000_00000040, 1'b1, 1'b0);
        send_rsp(1'b0, 64'h55550000_00000040, 8'hFF, 1, 1'b0);
        expect_rsp(32'h55550000, 1'b1);

        // Partial tkeep on the response beat
        send_cmd(1'b1, 28'h0ABCDEF, 32'h01020304, 1'b0);
        expect_req(64'hC0A80180_54770008, 64'h01020304_80ABCDEF, 1'b0, 1'b0);
        send_rsp(1'b0, 64'h01020304_80ABCDEF, 8'h0F, 1, 1'b0);
        expect_rsp(32'h01020304, 1'b1);

        // Three-beat response at max address: tail drained, one strobe
        send_cmd(1'b0, 28'hFFFFFFF, 32'h0, 1'b0);
        expect_req(64'hC0A80180_54720008, 64'h00000000_0FFFFFFF, 1'b1, 1'b0);
        send_rsp(1'b1, 64'hA5A5A5A5_0FFFFFFF, 8'hFF, 3, 1'b0);
        expect_rsp(32'hA5A5A5A5, 1'b0);
        repeat (3) @(negedge aclk);
        chk("drain_rsp_count", n_rsp, exp_rsp);

        // Stray frame in IDLE is swallowed
        send_rsp(1'b1, 64'h00000001_00000001, 8'hFF, 2, 1'b0);
        repeat (3) @(negedge aclk);
        chk("stray_rsp_count", n_rsp, exp_rsp);
        chk("stray_cmd_ready", cmd_ready, 1);

        // Reset while waiting for the response payload
        send_cmd(1'b1, 28'h0000123, 32'h11112222, 1'b0);
        expect_req(64'hC0A80180_54770008, 64'h11112222_80000123, 1'b0, 1'b0);
        send_rsp(1'b0, 64'h0, 8'hFF, 0, 1'b0);
        chk("in_wait_pay", s_payload_tready, 1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_hdr_tvalid", m_hdr_tvalid, 0);
        chk("mid_rst_hdr_tdata", m_hdr_tdata, 0);
        chk("mid_rst_hdr_tuser", m_hdr_tuser, 0);
        chk("mid_rst_pay_tvalid", m_payload_tvalid, 0);
        chk("mid_rst_pay_tdata", m_payload_tdata, 0);
        chk("mid_rst_pay_tkeep", m_payload_tkeep, 0);
        chk("mid_rst_pay_tlast", m_payload_tlast, 0);
        chk("mid_rst_s_hdr_tready", s_hdr_tready, 0);
        chk("mid_rst_s_pay_tready", s_payload_tready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_dat", rsp_dat, 0);
        chk("mid_rst_rsp_err", rsp_err, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rerst_cmd_ready", cmd_ready, 1);
        chk("rerst_rsp_count", n_rsp, exp_rsp);
        send_cmd(1'b0, 28'h0000007, 32'h0, 1'b0);
        expect_req(64'hC0A80180_54720008, 64'h00000000_00000007, 1'b1, 1'b0);
        send_rsp(1'b1, 64'h76543210_00000007, 8'hFF, 1, 1'b0);
        expect_rsp(32'h76543210, 1'b0);

`ifdef TURF_UDP_INIT_TIMEOUT_EN
        // No response: strobe 101 cycles after entering WAIT_HDR, late frame dropped
        begin
            int n;
            send_cmd(1'b0, 28'h0000099, 32'h0, 1'b0);
            expect_req(64'hC0A80180_54720008, 64'h00000000_00000099, 1'b1, 1'b0);
            n = 0;
            while (!rsp_valid && n < 200) begin
                @(negedge aclk);
                n++;
            end
            exp_rsp++;
            chk("tmo_cycles", 64'(n), 64'd101);
            chk("tmo_err", rsp_err, 1);
            chk("tmo_dat", rsp_dat, 32'hDEADDEAD);
            @(negedge aclk);
            chk("tmo_one_cycle", rsp_valid, 0);
            send_rsp(1'b1, 64'h0BADF00D_00000099, 8'hFF, 1, 1'b0);
            repeat (3) @(negedge aclk);
            chk("tmo_late_count", n_rsp, exp_rsp);
        end
`endif

        // 200 random commands with backpressure; responder echoes the request
        for (int i = 0; i < 200; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 28'($urandom);
            rd = $urandom;
            rr = $urandom;
            hi = rw ? rd : rr;
            send_cmd(rw, ra, rd, 1'b1);
            expect_req({DEST_IP, rw ? WR_PORT : RD_PORT, 16'd8},
                       {rw ? rd : 32'h0, rw, 3'b000, ra}, ~rw, 1'b1);
            send_rsp(~rw, {hi, rw, 3'b000, ra}, 8'hFF, int'($urandom_range(1, 2)), 1'b1);
            expect_rsp(hi, 1'b0);
        end
        repeat (3) @(negedge aclk);
        chk("final_rsp_count", n_rsp, exp_rsp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/turf_udp_rdwr_initiator.md
# turf_udp_rdwr_initiator

Initiator for the TURF UDP read/write control protocol. It turns single register commands into one request frame (header word plus one payload word) on an AXI4-Stream pair. It then waits for the matching response frame and returns the read data, or an error, on a response strobe. The block sits on the test/host side of the link, facing the control-port responder, so loopback benches and on-board masters can drive the same memory interface.

## Interface
Parameters:
- DEST_IP, 32'hC0A8_0180: destination IP placed in header bits [63:32].
- RD_PORT, 16'd21618: destination port for reads, placed in header bits [31:16].
- WR_PORT, 16'd21623: destination port for writes, placed in header bits [31:16].
- TIMEOUT, 16'd65535: response timeout in aclk cycles; only used when the timeout feature is compiled in.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_adr  in  28  register address.
- cmd_dat  in  32  write data (ignored on reads).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_dat  out  32  read data, or echoed write data.
- rsp_err  out  1  mismatch or timeout.
- m_hdr_tdata / tvalid / tready  out / out / in  64 / 1 / 1  request header stream.
- m_hdr_tuser  out  1  1 = read port.
- m_payload_tdata / tvalid / tready  out / out / in  64 / 1 / 1  request payload stream.
- m_payload_tkeep  out  8  request payload byte enables.
- m_payload_tlast  out  1  request payload last.
- s_hdr_tdata / tvalid / tready  in / in / out  64 / 1 / 1  response header stream.
- s_hdr_tuser  in  1  response port flag.
- s_payload_tdata / tvalid / tready  in / in / out  64 / 1 / 1  response payload stream.
- s_payload_tkeep  in  8  response payload byte enables.
- s_payload_tlast  in  1  response payload last.

## Operation
Request format:
- Header word = {DEST_IP, port, 16'd8}; m_hdr_tuser = ~wr.
- Payload word = {dat, wr, 3'b000, adr}; tkeep = 8'hFF; tlast = 1.
- For reads, the dat field is zero.

Command capture:
- The command is registered at cmd_valid & cmd_ready.
- cmd_ready is high only in IDLE.

States:
- IDLE → SEND_HDR when a command is accepted.
- SEND_HDR → SEND_PAY when m_hdr handshakes.
- SEND_PAY → WAIT_HDR when m_payload handshakes.
- WAIT_HDR: s_hdr_tready = 1. On header accept:
  - latch tuser_ok = (s_hdr_tuser == ~wr);
  - go to WAIT_PAY.
- WAIT_PAY: s_payload_tready = 1. On the first beat:
  - match = tuser_ok & (tdata[31:0] == request low word) & (tkeep == 8'hFF);
  - capture rsp_dat = tdata[63:32];
  - if tlast, go to DONE; otherwise go to DRAIN.
- DRAIN: discard beats until tlast, then go to DONE.
- DONE: assert rsp_valid for one cycle with rsp_err = ~match, then return to IDLE.

Stray traffic:
- In IDLE, both s_hdr_tready and s_payload_tready are 1, so stray frames are consumed and discarded.
- No rsp_valid is generated for stray frames.

Stream rules:
- m_hdr and m_payload are never valid at the same time.
- tdata is held stable while tvalid is high.

## Timing
- Reset values:
  - cmd_ready = 0 during reset, 1 on the first cycle after reset.
  - All other outputs are 0 during reset.
  - The state returns to IDLE.
  - Any in-flight command is lost, and no rsp_valid is issued.
- m_hdr_tvalid rises on the cycle after the command accept.
- m_payload_tvalid rises on the cycle after the header handshake.
- rsp_valid rises on the cycle after the tlast beat is accepted.
- Minimum command-to-command period with zero response latency and tready always high: 6 cycles.
- If a response header and a stray payload arrive together in WAIT_HDR, only the header is accepted (payload tready = 0).

## Configuration
Macro TURF_UDP_INIT_TIMEOUT_EN.

When defined:
- A 16-bit counter clears on entry to WAIT_HDR and increments in WAIT_HDR and WAIT_PAY.
- Reaching TIMEOUT forces DONE with rsp_err = 1 and rsp_dat = 32'hDEADDEAD.
- A late response is discarded in IDLE.

When undefined:
- The block waits for a response indefinitely; there is no counter logic.

## Structure
- The package turf_udp_pkg holds:
  - the FSM state enum (3 bits);
  - the header field offsets;
  - the payload field offsets (ADR_MSB=27, WR_BIT=31, DAT_LSB=32).
- The optional timeout counter is a natural sub-module, turf_udp_timeout (clear, run, expired).

## Test plan
- Read 0x0000010, responder returns {32'h12345678, 32'h00000010} with tuser = 1:
  - header = {DEST_IP, RD_PORT, 16'd8}, m_hdr_tuser = 1;
  - rsp_valid with rsp_dat = 0x12345678, rsp_err = 0.
- Write 0x0000020 data 0xCAFEF00D:
  - payload = 64'hCAFEF00D_80000020, m_hdr_tuser = 0;
  - echoed response gives rsp_err = 0.
- Response low word 0x00000011 against a request for 0x10 → rsp_err = 1.
- A 3-beat response frame → beats 2–3 are drained and exactly one rsp_valid is issued.
- Random tready/tvalid backpressure on all four streams → data remains stable while valid; 200 back-to-back commands all complete correctly.
- With TURF_UDP_INIT_TIMEOUT_EN and TIMEOUT = 100, no response → rsp_err = 1 at cycle 101 after entering WAIT_HDR.
- Reset asserted in WAIT_PAY → all outputs are 0; no rsp_valid is issued; the next command completes normally.
